wheel_state_buffer: RTL and testbench

WHEEL_STATE_BUFFER -- requirements
Module: wheel_state_buffer

---
 rtl/wheel_state_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_wheel_state_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wheel_state_buffer.sv
// -----------------------------------------------------------------------------
// wheel_state_buffer
//
// Double-buffered store for one wheel's node positions and velocities. The
// committed arrays drive the outputs; the wheel updater streams a new frame
// into shadow arrays, and the frame is copied across only when every node and
// every velocity slot was written before result_in arrived.
//
// Ports
//   clk_in                 single system clock, rising edge
//   rst_in                 asynchronous active-low reset
//   start_in               in IDLE: load init arrays and launch the first frame
//   run_in                 sampled in COMMIT: relaunch (1) or return to IDLE (0)
//   init_nodes_in          [0][i] = x, [1][i] = y initial node positions
//   init_velocities_in     [0][i] = x, [1][i] = y initial node velocities
//   node_x_in/node_y_in    streamed node position beat, node_valid_in qualifies
//   velocity_x_in/_y_in    streamed velocity beat, velocity_valid_in qualifies
//   result_in              updater finished the frame
//   nodes_out              committed node positions
//   velocities_out         committed velocities
//   begin_out              one-cycle pulse telling the updater to start a frame
//   busy_out               high whenever not in IDLE
//   frame_count_out        number of successful commits, wraps at 16 bits
//   err_overflow_out       sticky: a beat arrived with its slot counter full
//   err_short_out          sticky: a commit was aborted for missing beats
//
// Configuration
//   WHEEL_STATE_BUFFER_ERR_EN  when defined, the two error flags are built;
//                              otherwise both error outputs are tied to 0.
// -----------------------------------------------------------------------------
module wheel_state_buffer #(
   parameter int NUM_NODES     = 4,
   parameter int POSITION_SIZE = 17,
   parameter int VELOCITY_SIZE = 12
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            start_in,
   input  logic                            run_in,
   input  logic signed [POSITION_SIZE-1:0] init_nodes_in      [1:0][NUM_NODES],
   input  logic signed [VELOCITY_SIZE-1:0] init_velocities_in [1:0][NUM_NODES],
   input  logic signed [POSITION_SIZE-1:0] node_x_in,
   input  logic signed [POSITION_SIZE-1:0] node_y_in,
   input  logic                            node_valid_in,
   input  logic signed [VELOCITY_SIZE-1:0] velocity_x_in,
   input  logic signed [VELOCITY_SIZE-1:0] velocity_y_in,
   input  logic                            velocity_valid_in,
   input  logic                            result_in,
   output logic signed [POSITION_SIZE-1:0] nodes_out          [1:0][NUM_NODES],
   output logic signed [VELOCITY_SIZE-1:0] velocities_out     [1:0][NUM_NODES],
   output logic                            begin_out,
   output logic                            busy_out,
   output logic [15:0]                     frame_count_out,
   output logic                            err_overflow_out,
   output logic                            err_short_out
);

   // Counters must reach NUM_NODES itself (the "full" value), the slot index
   // only needs to address NUM_NODES entries.
   localparam int CW = $clog2(NUM_NODES + 1);
   localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
   localparam logic [CW-1:0] FULL = CW'(NUM_NODES);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, COMMIT} state_t;

   state_t state_q, state_d;

   logic signed [POSITION_SIZE-1:0] node_q      [1:0][NUM_NODES];
   logic signed [POSITION_SIZE-1:0] node_d      [1:0][NUM_NODES];
   logic signed [VELOCITY_SIZE-1:0] vel_q       [1:0][NUM_NODES];
   logic signed [VELOCITY_SIZE-1:0] vel_d       [1:0][NUM_NODES];
   logic signed [POSITION_SIZE-1:0] shad_node_q [1:0][NUM_NODES];
   logic signed [POSITION_SIZE-1:0] shad_node_d [1:0][NUM_NODES];
   logic signed [VELOCITY_SIZE-1:0] shad_vel_q  [1:0][NUM_NODES];
   logic signed [VELOCITY_SIZE-1:0] shad_vel_d  [1:0][NUM_NODES];

   logic [CW-1:0] node_cnt_q, node_cnt_d;
   logic [CW-1:0] vel_cnt_q, vel_cnt_d;
   logic [15:0]   frame_q, frame_d;

   logic          node_full;
   logic          vel_full;
   logic          full_commit;
   logic [IW-1:0] node_idx;
   logic [IW-1:0] vel_idx;

   assign node_full   = (node_cnt_q == FULL);
   assign vel_full    = (vel_cnt_q == FULL);
   assign full_commit = node_full && vel_full;
   // Only used when the counter is below FULL, so truncation is safe.
   assign node_idx    = node_cnt_q[IW-1:0];
   assign vel_idx     = vel_cnt_q[IW-1:0];

   always_comb begin
      state_d     = state_q;
      node_d      = node_q;
      vel_d       = vel_q;
      shad_node_d = shad_node_q;
      shad_vel_d  = shad_vel_q;
      node_cnt_d  = node_cnt_q;
      vel_cnt_d   = vel_cnt_q;
      frame_d     = frame_q;

      case (state_q)
         IDLE: begin
            if (start_in) begin
               node_d     = init_nodes_in;
               vel_d      = init_velocities_in;
               node_cnt_d = '0;
               vel_cnt_d  = '0;
               state_d    = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            // Streams are independent; a beat landing with result_in is still
            // counted because COMMIT looks at the registered counters.
            if (node_valid_in && !node_full) begin
               shad_node_d[0][node_idx] = node_x_in;
               shad_node_d[1][node_idx] = node_y_in;
               node_cnt_d               = node_cnt_q + 1'b1;
            end
            if (velocity_valid_in && !vel_full) begin
               shad_vel_d[0][vel_idx] = velocity_x_in;
               shad_vel_d[1][vel_idx] = velocity_y_in;
               vel_cnt_d              = vel_cnt_q + 1'b1;
            end
            if (result_in) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            if (full_commit) begin
               node_d  = shad_node_q;
               vel_d   = shad_vel_q;
               frame_d = frame_q + 16'd1;
            end
            node_cnt_d = '0;
            vel_cnt_d  = '0;
            state_d    = run_in ? LAUNCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         node_q      <= '{default: '0};
         vel_q       <= '{default: '0};
         shad_node_q <= '{default: '0};
         shad_vel_q  <= '{default: '0};
         node_cnt_q  <= '0;
         vel_cnt_q   <= '0;
         frame_q     <= '0;
      end else begin
         state_q     <= state_d;
         node_q      <= node_d;
         vel_q       <= vel_d;
         shad_node_q <= shad_node_d;
         shad_vel_q  <= shad_vel_d;
         node_cnt_q  <= node_cnt_d;
         vel_cnt_q   <= vel_cnt_d;
         frame_q     <= frame_d;
      end
   end

   assign nodes_out       = node_q;
   assign velocities_out  = vel_q;
   assign frame_count_out = frame_q;
   assign begin_out       = (state_q == LAUNCH);
   assign busy_out        = (state_q != IDLE);

`ifdef WHEEL_STATE_BUFFER_ERR_EN
   logic err_ovf_q, err_ovf_d;
   logic err_short_q, err_short_d;

   always_comb begin
      err_ovf_d   = err_ovf_q;
      err_short_d = err_short_q;
      if (state_q == IDLE && start_in) begin
         err_ovf_d   = 1'b0;
         err_short_d = 1'b0;
      end else begin
         if (state_q == WAIT &&
             ((node_valid_in && node_full) || (velocity_valid_in && vel_full))) begin
            err_ovf_d = 1'b1;
         end
         if (state_q == COMMIT && !full_commit) begin
            err_short_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         err_ovf_q   <= 1'b0;
         err_short_q <= 1'b0;
      end else begin
         err_ovf_q   <= err_ovf_d;
         err_short_q <= err_short_d;
      end
   end

   assign err_overflow_out = err_ovf_q;
   assign err_short_out    = err_short_q;
`else
   assign err_overflow_out = 1'b0;
   assign err_short_out    = 1'b0;
`endif

endmodule

// File: tb/tb_wheel_state_buffer.sv
// -----------------------------------------------------------------------------
// tb_wheel_state_buffer
//
// Directed bench for wheel_state_buffer with default parameters. Inputs are
// driven and outputs sampled 1 time unit after each rising edge. Expected
// committed arrays are kept in exp_n / exp_v and set by hand at each step.
// -----------------------------------------------------------------------------
module tb_wheel_state_buffer;

   localparam int N  = 4;
   localparam int PS = 17;
   localparam int VS = 12;
`ifdef WHEEL_STATE_BUFFER_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic                 start_in;
   logic                 run_in;
   logic signed [PS-1:0] init_nodes [1:0][N];
   logic signed [VS-1:0] init_vels  [1:0][N];
   logic signed [PS-1:0] node_x, node_y;
   logic                 node_valid;
   logic signed [VS-1:0] vel_x, vel_y;
   logic                 vel_valid;
   logic                 result;
   logic signed [PS-1:0] nodes_out      [1:0][N];
   logic signed [VS-1:0] velocities_out [1:0][N];
   logic                 begin_out;
   logic                 busy_out;
   logic [15:0]          frame_count_out;
   logic                 err_overflow_out;
   logic                 err_short_out;

   int n_assert = 0;
   int n_fail   = 0;
   int exp_n [1:0][N];
   int exp_v [1:0][N];

   wheel_state_buffer #(.NUM_NODES(N), .POSITION_SIZE(PS), .VELOCITY_SIZE(VS)) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .start_in           (start_in),
      .run_in             (run_in),
      .init_nodes_in      (init_nodes),
      .init_velocities_in (init_vels),
      .node_x_in          (node_x),
      .node_y_in          (node_y),
      .node_valid_in      (node_valid),
      .velocity_x_in      (vel_x),
      .velocity_y_in      (vel_y),
      .velocity_valid_in  (vel_valid),
      .result_in          (result),
      .nodes_out          (nodes_out),
      .velocities_out     (velocities_out),
      .begin_out          (begin_out),
      .busy_out           (busy_out),
      .frame_count_out    (frame_count_out),
      .err_overflow_out   (err_overflow_out),
      .err_short_out      (err_short_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_arrays(input string tag);
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) begin
            chk($sformatf("%s nodes[%0d][%0d]", tag, d, i), nodes_out[d][i], exp_n[d][i]);
            chk($sformatf("%s vels[%0d][%0d]", tag, d, i), velocities_out[d][i], exp_v[d][i]);
         end
      end
   endtask

   task automatic chk_status(input string tag, input logic bsy, input logic beg,
                             input int frm, input logic ovf, input logic sht);
      chk({tag, " busy"},  busy_out, bsy);
      chk({tag, " begin"}, begin_out, beg);
      chk({tag, " frame"}, frame_count_out, frm);
      chk({tag, " ovf"},   err_overflow_out, ovf);
      chk({tag, " short"}, err_short_out, sht);
   endtask

   initial begin
      rst_in = 1'b0; start_in = 1'b0; run_in = 1'b0;
      node_x = '0; node_y = '0; node_valid = 1'b0;
      vel_x = '0; vel_y = '0; vel_valid = 1'b0; result = 1'b0;
      init_nodes[0][0] = -17'sd30; init_nodes[1][0] = -17'sd20;
      init_nodes[0][1] = -17'sd20; init_nodes[1][1] =  17'sd20;
      init_nodes[0][2] =  17'sd20; init_nodes[1][2] =  17'sd20;
      init_nodes[0][3] =  17'sd30; init_nodes[1][3] = -17'sd20;
      init_vels[0][0] = 12'sd5;  init_vels[1][0] = -12'sd1;
      init_vels[0][1] = 12'sd6;  init_vels[1][1] = -12'sd2;
      init_vels[0][2] = 12'sd7;  init_vels[1][2] = -12'sd3;
      init_vels[0][3] = 12'sd8;  init_vels[1][3] = -12'sd4;

      // Reset state
      tick(); tick();
      exp_n = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
      exp_v = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
      chk_arrays("reset");
      chk_status("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0);
      rst_in = 1'b1;
      tick(); tick();
      chk_status("idle-hold", 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Start: init arrays appear next cycle, begin pulses once
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      exp_n = '{'{-20, 20, 20, -20}, '{-30, -20, 20, 30}};
      exp_v = '{'{-1, -2, -3, -4}, '{5, 6, 7, 8}};
      chk_arrays("start");
      chk_status("start", 1'b1, 1'b1, 0, 1'b0, 1'b0);
      tick();
      chk({"start-after", " begin"}, begin_out, 1'b0);
      $display("txn start: nodes loaded, frame=%0d", frame_count_out);

      // Full frame; last beat concurrent with result_in
      run_in = 1'b1;
      for (int i = 0; i < N; i++) begin
         node_valid = 1'b1; node_x = PS'(i + 1); node_y = PS'(-(i + 1));
         vel_valid  = 1'b1; vel_x  = VS'(10 * (i + 1)); vel_y = VS'(-2 * (i + 1));
         result     = (i == N - 1);
         tick();
      end
      node_valid = 1'b0; vel_valid = 1'b0; result = 1'b0;
      chk("full N+1 begin", begin_out, 1'b0);
      chk("full N+1 node[0][3]", nodes_out[0][3], 30);
      tick();
      exp_n = '{'{-1, -2, -3, -4}, '{1, 2, 3, 4}};
      exp_v = '{'{-2, -4, -6, -8}, '{10, 20, 30, 40}};
      chk_arrays("full");
      chk_status("full", 1'b1, 1'b1, 1, 1'b0, 1'b0);
      $display("txn commit: frame=%0d node[0][3]=%0d node[1][3]=%0d",
               frame_count_out, nodes_out[0][3], nodes_out[1][3]);
      tick();

      // Overflow: five node beats, the fifth is dropped
      for (int i = 0; i < 5; i++) begin
         node_valid = 1'b1; node_x = PS'(100 + i); node_y = PS'(-(100 + i));
         vel_valid  = (i < 4); vel_x = VS'(50 + i); vel_y = VS'(-(50 + i));
         tick();
      end
      node_valid = 1'b0; vel_valid = 1'b0; result = 1'b1;
      tick();
      result = 1'b0;
      tick();
      exp_n = '{'{-100, -101, -102, -103}, '{100, 101, 102, 103}};
      exp_v = '{'{-50, -51, -52, -53}, '{50, 51, 52, 53}};
      chk_arrays("ovf");
      chk_status("ovf", 1'b1, 1'b1, 2, ERR_EN, 1'b0);
      $display("txn commit: frame=%0d ovf=%0b", frame_count_out, err_overflow_out);
      tick();

      // Short frame: three node beats, commit aborted; run_in=0 -> IDLE
      run_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         node_valid = (i < 3); node_x = PS'(200 + i); node_y = PS'(200 + i);
         vel_valid  = 1'b1;    vel_x  = VS'(300 + i); vel_y = VS'(300 + i);
         tick();
      end
      node_valid = 1'b0; vel_valid = 1'b0; result = 1'b1;
      tick();
      result = 1'b0;
      chk("short commit busy", busy_out, 1'b1);
      tick();
      chk_arrays("short");
      chk_status("short", 1'b0, 1'b0, 2, ERR_EN, ERR_EN);
      $display("txn abort: frame=%0d short=%0b", frame_count_out, err_short_out);
      tick();
      chk("idle no begin", begin_out, 1'b0);

      // Beats and result_in in IDLE are ignored
      node_valid = 1'b1; vel_valid = 1'b1; result = 1'b1;
      node_x = PS'(77); node_y = PS'(77);
      tick(); tick(); tick();
      node_valid = 1'b0; vel_valid = 1'b0; result = 1'b0;
      chk_arrays("idle-ignore");
      chk_status("idle-ignore", 1'b0, 1'b0, 2, ERR_EN, ERR_EN);

      // Restart clears flags, then reset mid-stream
      run_in = 1'b1; start_in = 1'b1;
      tick();
      start_in = 1'b0;
      exp_n = '{'{-20, 20, 20, -20}, '{-30, -20, 20, 30}};
      exp_v = '{'{-1, -2, -3, -4}, '{5, 6, 7, 8}};
      chk_arrays("restart");
      chk_status("restart", 1'b1, 1'b1, 2, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         node_valid = 1'b1; node_x = PS'(9); node_y = PS'(9);
         tick();
      end
      node_valid = 1'b0;
      rst_in = 1'b0;
      #1;
      exp_n = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
      exp_v = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
      chk_arrays("midrst");
      chk_status("midrst", 1'b0, 1'b0, 0, 1'b0, 1'b0);
      $display("txn reset: busy=%0b frame=%0d", busy_out, frame_count_out);
      tick();
      rst_in = 1'b1;

      // Four beats plus result before start_in leave everything at zero
      for (int i = 0; i < 4; i++) begin
         node_valid = 1'b1; node_x = PS'(i + 1); node_y = PS'(i + 1);
         vel_valid  = 1'b1; vel_x  = VS'(i + 1); vel_y  = VS'(i + 1);
         result     = (i == 3);
         tick();
      end
      node_valid = 1'b0; vel_valid = 1'b0; result = 1'b0;
      tick(); tick();
      chk_arrays("post-rst");
      chk_status("post-rst", 1'b0, 1'b0, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
